// File: rtl/ppg_spo2_calc_pkg.sv
`default_nettype none
// ============================================================================
// ppg_pkg : shared state encoding, Q-format and SpO2 mapping constants
// Rev 1.0
// ============================================================================
package ppg_pkg;

    localparam int WINDOW_DEFAULT      = 256;
    localparam int LOG2_WINDOW_DEFAULT = 8;

    localparam int FRAC_BITS   = 8;
    localparam int SPO2_OFFSET = 110;
    localparam int SPO2_SLOPE  = 25;
    localparam int SPO2_MAX    = 100;
    localparam int RATIO_SAT   = 1023;

    localparam int NUM_W = 24;
    localparam int DEN_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd1,
        ST_MUL   = 3'd2,
        ST_DIV   = 3'd3,
        ST_CALC  = 3'd4
    } state_t;

    // Smallest SpO2 reachable is 110 - 99 = 11, so the subtraction never wraps.
    function automatic logic [6:0] spo2_from_ratio(input logic [9:0] ratio);
        logic [14:0] w_scaled;
        logic [14:0] w_raw;
        w_scaled = 15'(SPO2_SLOPE) * {5'd0, ratio};
        w_raw    = 15'(SPO2_OFFSET) - (w_scaled >> FRAC_BITS);
        return (w_raw > 15'(SPO2_MAX)) ? 7'(SPO2_MAX) : 7'(w_raw);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ppg_spo2_calc_if.sv
`default_nettype none
// ============================================================================
// ppg_spo2_calc_if : sample inputs and result outputs of the SpO2 calculator
// Rev 1.0
// ============================================================================
interface ppg_spo2_calc_if;
    logic       setting_done;
    logic [7:0] red_sample;
    logic       red_valid;
    logic [7:0] ir_sample;
    logic       ir_valid;
    logic [6:0] spo2;
    logic [9:0] ratio_q8;
    logic       result_valid;
    logic       result_err;
    logic       overrun;

    modport master (
        output setting_done, red_sample, red_valid, ir_sample, ir_valid,
        input  spo2, ratio_q8, result_valid, result_err, overrun
    );

    modport slave (
        input  setting_done, red_sample, red_valid, ir_sample, ir_valid,
        output spo2, ratio_q8, result_valid, result_err, overrun
    );
endinterface
`default_nettype wire

// File: rtl/ppg_spo2_calc_div.sv
`default_nettype none
// ============================================================================
// ppg_seq_div : 24/16 unsigned restoring divider, one quotient bit per cycle
// Rev 1.0
// ============================================================================
module ppg_seq_div
    import ppg_pkg::*;
(
    input  wire              clk,
    input  wire              rst,
    input  wire              start,
    input  wire              abort,
    input  wire [NUM_W-1:0]  num,
    input  wire [DEN_W-1:0]  den,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] quot
);
    logic [DEN_W-1:0] r_rem_q,  r_rem_d;
    logic [NUM_W-1:0] r_quot_q, r_quot_d;
    logic [DEN_W-1:0] r_den_q,  r_den_d;
    logic [4:0]       r_cnt_q,  r_cnt_d;
    logic             r_busy_q, r_busy_d;
    logic [DEN_W:0]   w_trial;
    logic             w_fits;

    // Dividend bits shift out of the top of the quotient register as quotient bits shift in.
    assign w_trial = {r_rem_q, r_quot_q[NUM_W-1]};
    assign w_fits  = (w_trial >= {1'b0, r_den_q});

    always_comb begin
        r_rem_d  = r_rem_q;
        r_quot_d = r_quot_q;
        r_den_d  = r_den_q;
        r_cnt_d  = r_cnt_q;
        r_busy_d = r_busy_q;
        if (abort) begin
            r_busy_d = 1'b0;
            r_cnt_d  = '0;
        end else if (start) begin
            r_rem_d  = '0;
            r_quot_d = num;
            r_den_d  = den;
            r_cnt_d  = 5'(NUM_W);
            r_busy_d = 1'b1;
        end else if (r_busy_q) begin
            r_rem_d  = w_fits ? DEN_W'(w_trial - {1'b0, r_den_q}) : DEN_W'(w_trial);
            r_quot_d = {r_quot_q[NUM_W-2:0], w_fits};
            r_cnt_d  = r_cnt_q - 5'd1;
            r_busy_d = (r_cnt_q != 5'd1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem_q  <= '0;
            r_quot_q <= '0;
            r_den_q  <= '0;
            r_cnt_q  <= '0;
            r_busy_q <= 1'b0;
        end else begin
            r_rem_q  <= r_rem_d;
            r_quot_q <= r_quot_d;
            r_den_q  <= r_den_d;
            r_cnt_q  <= r_cnt_d;
            r_busy_q <= r_busy_d;
        end
    end

    // High during the final iteration so the caller can step on the same edge the quotient settles.
    assign done = r_busy_q && (r_cnt_q == 5'd1);
    assign busy = r_busy_q;
    assign quot = r_quot_q;
endmodule
`default_nettype wire

// File: rtl/ppg_spo2_calc.sv
`default_nettype none
// ============================================================================
// ppg_spo2_calc : windowed AC/DC extraction, ratio-of-ratios and SpO2 mapping
// Rev 1.0
// ============================================================================
module ppg_spo2_calc
    import ppg_pkg::*;
#(
    parameter int WINDOW      = WINDOW_DEFAULT,
    parameter int LOG2_WINDOW = LOG2_WINDOW_DEFAULT
) (
    input wire             CLK,
    input wire             rst,
    ppg_spo2_calc_if.slave bus
);
    localparam int c_sum_w = 8 + LOG2_WINDOW;
    localparam int c_cnt_w = LOG2_WINDOW + 1;
    localparam logic [c_cnt_w-1:0] c_win_cnt = c_cnt_w'(WINDOW);

    // Channel index 0 is RED, 1 is IR.
    logic [7:0]         w_smp [2];
    logic [1:0]         w_vld;
    logic [1:0]         w_full;
    logic               w_close;

    logic [7:0]         r_max_q [2], r_max_d [2];
    logic [7:0]         r_min_q [2], r_min_d [2];
    logic [c_sum_w-1:0] r_sum_q [2], r_sum_d [2];
    logic [c_cnt_w-1:0] r_cnt_q [2], r_cnt_d [2];
    logic [7:0]         r_ac_q  [2], r_ac_d  [2];
    logic [7:0]         r_dc_q  [2], r_dc_d  [2];

    state_t             r_state_q, r_state_d;
    logic               r_err_q, r_err_d;
    logic [6:0]         r_spo2_q, r_spo2_d;
    logic [9:0]         r_ratio_q, r_ratio_d;
    logic               r_valid_q, r_valid_d;
    logic               r_res_err_q, r_res_err_d;
    logic               r_overrun_q, r_overrun_d;

    logic [15:0]        w_num_prod;
    logic [NUM_W-1:0]   w_num;
    logic [DEN_W-1:0]   w_den;
    logic [NUM_W-1:0]   w_quot;
    logic [9:0]         w_ratio;
    logic               w_div_start;
    logic               w_div_abort;
    logic               w_div_busy;
    logic               w_div_done;

    assign w_smp[0] = bus.red_sample;
    assign w_smp[1] = bus.ir_sample;
    assign w_vld    = {bus.ir_valid, bus.red_valid};
    assign w_full   = {r_cnt_q[1] == c_win_cnt, r_cnt_q[0] == c_win_cnt};
    assign w_close  = &w_full;

    assign w_num_prod  = 16'(r_ac_q[0]) * 16'(r_dc_q[1]);
    assign w_num       = {w_num_prod, {FRAC_BITS{1'b0}}};
    assign w_den       = 16'(r_ac_q[1]) * 16'(r_dc_q[0]);
    assign w_ratio     = (w_quot > NUM_W'(RATIO_SAT)) ? 10'(RATIO_SAT) : 10'(w_quot);
    assign w_div_abort = !bus.setting_done;

    // Accumulators restart on window close so the next window overlaps the compute.
    always_comb begin
        r_max_d = r_max_q;
        r_min_d = r_min_q;
        r_sum_d = r_sum_q;
        r_cnt_d = r_cnt_q;
        for (int c = 0; c < 2; c++) begin
            if (!bus.setting_done || w_close) begin
                r_max_d[c] = '0;
                r_min_d[c] = '1;
                r_sum_d[c] = '0;
                r_cnt_d[c] = '0;
            end else if (w_vld[c] && !w_full[c]) begin
                if (w_smp[c] > r_max_q[c]) r_max_d[c] = w_smp[c];
                if (w_smp[c] < r_min_q[c]) r_min_d[c] = w_smp[c];
                r_sum_d[c] = r_sum_q[c] + c_sum_w'(w_smp[c]);
                r_cnt_d[c] = r_cnt_q[c] + c_cnt_w'(1);
            end
        end
    end

    always_comb begin
        r_state_d   = r_state_q;
        r_ac_d      = r_ac_q;
        r_dc_d      = r_dc_q;
        r_err_d     = r_err_q;
        r_spo2_d    = r_spo2_q;
        r_ratio_d   = r_ratio_q;
        r_valid_d   = 1'b0;
        r_res_err_d = r_res_err_q;
        r_overrun_d = r_overrun_q;
        w_div_start = 1'b0;
        if (!bus.setting_done) begin
            r_state_d = ST_IDLE;
        end else begin
            case (r_state_q)
                ST_IDLE: r_state_d = ST_ACCUM;
                ST_ACCUM: begin
                    if (w_close) begin
                        for (int c = 0; c < 2; c++) begin
                            r_ac_d[c] = r_max_q[c] - r_min_q[c];
                            r_dc_d[c] = r_sum_q[c][c_sum_w-1:LOG2_WINDOW];
                        end
                        r_state_d = ST_MUL;
                    end
                end
                ST_MUL: begin
                    r_err_d     = (w_den == '0);
                    w_div_start = 1'b1;
                    r_state_d   = ST_DIV;
                end
                ST_DIV: begin
                    // The busy term only guards against stranding here if the divider ever idles early.
                    if (w_div_done || !w_div_busy) r_state_d = ST_CALC;
                end
                ST_CALC: begin
                    r_valid_d   = 1'b1;
                    r_res_err_d = r_err_q;
                    r_ratio_d   = r_err_q ? 10'(RATIO_SAT) : w_ratio;
                    r_spo2_d    = r_err_q ? 7'd0 : spo2_from_ratio(w_ratio);
                    r_state_d   = ST_ACCUM;
                end
                default: r_state_d = ST_IDLE;
            endcase
            if (w_close && (r_state_q == ST_MUL || r_state_q == ST_DIV || r_state_q == ST_CALC))
                r_overrun_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                r_max_q[c] <= '0;
                r_min_q[c] <= '1;
                r_sum_q[c] <= '0;
                r_cnt_q[c] <= '0;
                r_ac_q[c]  <= '0;
                r_dc_q[c]  <= '0;
            end
            r_state_q   <= ST_IDLE;
            r_err_q     <= 1'b0;
            r_spo2_q    <= '0;
            r_ratio_q   <= '0;
            r_valid_q   <= 1'b0;
            r_res_err_q <= 1'b0;
            r_overrun_q <= 1'b0;
        end else begin
            r_max_q     <= r_max_d;
            r_min_q     <= r_min_d;
            r_sum_q     <= r_sum_d;
            r_cnt_q     <= r_cnt_d;
            r_ac_q      <= r_ac_d;
            r_dc_q      <= r_dc_d;
            r_state_q   <= r_state_d;
            r_err_q     <= r_err_d;
            r_spo2_q    <= r_spo2_d;
            r_ratio_q   <= r_ratio_d;
            r_valid_q   <= r_valid_d;
            r_res_err_q <= r_res_err_d;
            r_overrun_q <= r_overrun_d;
        end
    end

    ppg_seq_div u_div (
        .clk   (CLK),
        .rst   (rst),
        .start (w_div_start),
        .abort (w_div_abort),
        .num   (w_num),
        .den   (w_den),
        .busy  (w_div_busy),
        .done  (w_div_done),
        .quot  (w_quot)
    );

    assign bus.spo2         = r_spo2_q;
    assign bus.ratio_q8     = r_ratio_q;
    assign bus.result_valid = r_valid_q;
    assign bus.result_err   = r_res_err_q;
    assign bus.overrun      = r_overrun_q;
endmodule
`default_nettype wire

// File: tb/tb_ppg_spo2_calc.sv
`default_nettype none
// ============================================================================
// tb_ppg_spo2_calc : directed windows checked against a window-level model
// Rev 1.0
// ============================================================================
module tb_ppg_spo2_calc;
    localparam int W = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ppg_spo2_calc_if sp  ();
    ppg_spo2_calc_if sp2 ();

    ppg_spo2_calc #(.WINDOW(W), .LOG2_WINDOW(8)) dut  (.CLK(clk), .rst(rst), .bus(sp));
    ppg_spo2_calc #(.WINDOW(2), .LOG2_WINDOW(1)) dut2 (.CLK(clk), .rst(rst), .bus(sp2));

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int due; int spo2; int ratio; int err; } exp_t;
    exp_t exp_q[$];
    int   red_win[$];
    int   ir_win[$];
    bit   close_pending = 1'b0;
    int   held_spo2 = 0, held_ratio = 0, held_err = 0;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Result of one complete window, straight from the arithmetic definition.
    function automatic exp_t model_result(input int due);
        exp_t e;
        int mx_r, mn_r, sm_r, mx_i, mn_i, sm_i, num, den, q;
        mx_r = 0; mn_r = 255; sm_r = 0;
        mx_i = 0; mn_i = 255; sm_i = 0;
        foreach (red_win[i]) begin
            if (red_win[i] > mx_r) mx_r = red_win[i];
            if (red_win[i] < mn_r) mn_r = red_win[i];
            sm_r += red_win[i];
        end
        foreach (ir_win[i]) begin
            if (ir_win[i] > mx_i) mx_i = ir_win[i];
            if (ir_win[i] < mn_i) mn_i = ir_win[i];
            sm_i += ir_win[i];
        end
        num = (mx_r - mn_r) * (sm_i / W) * 256;
        den = (mx_i - mn_i) * (sm_r / W);
        e.due = due;
        if (den == 0) begin
            e.err = 1; e.ratio = 1023; e.spo2 = 0;
        end else begin
            q = num / den;
            e.err   = 0;
            e.ratio = (q > 1023) ? 1023 : q;
            e.spo2  = 110 - (25 * e.ratio) / 256;
            if (e.spo2 > 100) e.spo2 = 100;
        end
        return e;
    endfunction

    task automatic model_reset();
        red_win.delete();
        ir_win.delete();
        exp_q.delete();
        close_pending = 1'b0;
        held_spo2 = 0; held_ratio = 0; held_err = 0;
    endtask

    // Applies one cycle of stimulus and advances the model for the edge that registers it.
    task automatic drive(input bit sd, input bit rv, input int rs, input bit iv, input int irs);
        int e;
        @(negedge clk);
        sp.setting_done = sd;
        sp.red_valid    = rv;
        sp.red_sample   = 8'(rs);
        sp.ir_valid     = iv;
        sp.ir_sample    = 8'(irs);
        e = cyc + 1;
        if (!sd) begin
            red_win.delete();
            ir_win.delete();
            close_pending = 1'b0;
            while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due >= e) void'(exp_q.pop_back());
        end else if (close_pending) begin
            close_pending = 1'b0;
            red_win.delete();
            ir_win.delete();
        end else begin
            if (rv && red_win.size() < W) red_win.push_back(rs);
            if (iv && ir_win.size() < W)  ir_win.push_back(irs);
            if (red_win.size() == W && ir_win.size() == W) begin
                exp_q.push_back(model_result(e + 27));
                close_pending = 1'b1;
            end
        end
    endtask

    task automatic idle(input bit sd, input int n);
        for (int i = 0; i < n; i++) drive(sd, 0, 0, 0, 0);
    endtask

    task automatic win(input int r0, input int r1, input int i0, input int i1);
        for (int i = 0; i < W; i++) drive(1, 1, (i % 2) ? r1 : r0, 1, (i % 2) ? i1 : i0);
    endtask

    task automatic lit(input string tag, input int ratio, input int spo2, input int err);
        @(negedge clk);
        check({tag, "_ratio"}, sp.ratio_q8, ratio);
        check({tag, "_spo2"}, sp.spo2, spo2);
        check({tag, "_err"}, sp.result_err, err);
    endtask

    initial begin : cmp
        bit   ev;
        exp_t h;
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
            ev = (exp_q.size() > 0 && exp_q[0].due == cyc);
            check("result_valid", sp.result_valid, ev);
            if (ev) begin
                h = exp_q.pop_front();
                held_spo2 = h.spo2; held_ratio = h.ratio; held_err = h.err;
            end
            check("spo2", sp.spo2, held_spo2);
            check("ratio_q8", sp.ratio_q8, held_ratio);
            check("result_err", sp.result_err, held_err);
            check("overrun", sp.overrun, 0);
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int k, pulses, pcyc;
        sp.setting_done = 0; sp.red_valid = 0; sp.red_sample = 0; sp.ir_valid = 0; sp.ir_sample = 0;
        sp2.setting_done = 0; sp2.red_valid = 0; sp2.red_sample = 0; sp2.ir_valid = 0; sp2.ir_sample = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("rst_spo2", sp.spo2, 0);
        check("rst_ratio", sp.ratio_q8, 0);
        check("rst_valid", sp.result_valid, 0);
        check("rst_err", sp.result_err, 0);
        check("rst_overrun", sp.overrun, 0);

        idle(1, 2);
        win(100, 100, 100, 100);       // AC zero on both channels
        idle(1, 30);
        lit("aczero", 1023, 0, 1);

        win(90, 110, 80, 120);         // typical
        idle(1, 30);
        lit("typical", 128, 98, 0);

        win(0, 255, 127, 128);         // ratio saturation
        idle(1, 30);
        lit("sat", 1023, 11, 0);

        win(100, 101, 28, 228);        // SpO2 clamp
        idle(1, 30);
        lit("clamp", 1, 100, 0);

        for (int i = 0; i < 300; i++) drive(1, 1, (i < W) ? ((i % 2) ? 110 : 90) : 0, 0, 0);
        for (int i = 0; i < W; i++)   drive(1, 0, 0, 1, (i % 2) ? 120 : 80);
        idle(1, 30);
        lit("imbal", 128, 98, 0);

        for (int i = 0; i < 100; i++) drive(1, 1, (i % 2) ? 110 : 90, 1, (i % 2) ? 120 : 80);
        idle(0, 5);                    // setting_done low: partial window dropped
        idle(1, 2);
        win(0, 255, 127, 128);
        idle(1, 30);
        lit("abort", 1023, 11, 0);

        win(90, 110, 80, 120);
        idle(1, 10);                   // divider is mid-run here
        @(negedge clk);
        rst = 1;
        model_reset();
        #1;
        check("rstdiv_spo2", sp.spo2, 0);
        check("rstdiv_ratio", sp.ratio_q8, 0);
        check("rstdiv_valid", sp.result_valid, 0);
        @(negedge clk);
        rst = 0;
        idle(1, 40);

        // Overrun on the two-sample instance: a second window closes inside DIV.
        @(negedge clk);
        sp2.setting_done = 1;
        @(negedge clk);
        k = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 3) check("ovr_early", sp2.overrun, 0);
            sp2.red_valid  = 1;
            sp2.red_sample = 8'((i % 2) ? 110 : 90);
            sp2.ir_valid   = 1;
            sp2.ir_sample  = 8'((i % 2) ? 120 : 80);
            if (i == 1) k = cyc + 1;
        end
        @(negedge clk);
        sp2.red_valid = 0;
        sp2.ir_valid  = 0;
        pulses = 0;
        pcyc   = -1;
        while (cyc < k + 35) begin
            @(posedge clk);
            #1;
            if (sp2.result_valid) begin
                pulses++;
                pcyc = cyc;
                check("ovr_res_ratio", sp2.ratio_q8, 128);
                check("ovr_res_spo2", sp2.spo2, 98);
                check("ovr_res_err", sp2.result_err, 0);
            end
        end
        check("ovr_pulses", pulses, 1);
        check("ovr_latency", pcyc - k, 27);
        check("ovr_flag", sp2.overrun, 1);
        repeat (10) @(negedge clk);
        check("ovr_sticky", sp2.overrun, 1);
        check("ovr_held_ratio", sp2.ratio_q8, 128);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
